// File: rtl/pc_pkg.sv
// pc_pkg: shared op codes, FSM states and default sizes for the program-counter sequencer.
package pc_pkg;
  localparam int PC_ADDR_W = 12;
  localparam int PC_STACK_DEPTH = 8;
  typedef enum logic [2:0] {
    NEXT   = 3'd0,
    JUMP   = 3'd1,
    BRANCH = 3'd2,
    CALL   = 3'd3,
    RET    = 3'd4
  } pc_op_t;
  typedef enum logic {
    RUN      = 1'b0,
    RET_WAIT = 1'b1
  } pc_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: op request, return-stack and status signals between core and sequencer.
import pc_pkg::*;
interface pc_sequencer_if #(parameter int ADDR_W = PC_ADDR_W) ();
  logic              en;
  pc_op_t            op;
  logic [ADDR_W-1:0] target;
  logic              taken;
  logic [ADDR_W-1:0] stack_top;
  logic              stack_push;
  logic              stack_pop;
  logic [ADDR_W-1:0] stack_addr;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              err;
  modport master (output en, op, target, taken, stack_top,
                  input stack_push, stack_pop, stack_addr, pc, busy, err);
  modport slave  (input en, op, target, taken, stack_top,
                  output stack_push, stack_pop, stack_addr, pc, busy, err);
endinterface

// File: rtl/call_depth_counter.sv
// call_depth_counter: saturating 0..DEPTH up/down counter flagging overflow and underflow attempts.
module call_depth_counter #(
  parameter int DEPTH = 8,
  localparam int W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic ovf,
  output logic unf
);
  logic [W-1:0] depth;
  assign ovf = inc && depth == W'(DEPTH);
  assign unf = dec && depth == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) depth <= '0;
    else if (inc && !ovf) depth <= depth + 1'b1;
    else if (dec && !unf) depth <= depth - 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register plus next-address FSM driving the return-address stack.
// Define PC_STACK_GUARD_EN to track call depth and flag stack overflow/underflow on err.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int ADDR_W = PC_ADDR_W,
  parameter int DEPTH = PC_STACK_DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  pc_sequencer_if.slave bus
);
  pc_state_t state, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, nxt;
  logic push_q, push_d, pop_q, pop_d, ovf, unf;
  assign nxt = pc_q + ADDR_W'(1);
`ifdef PC_STACK_GUARD_EN
  logic is_call, is_ret, err_q;
  assign is_call = state == RUN && bus.en && bus.op == CALL;
  assign is_ret = state == RUN && bus.en && bus.op == RET;
  call_depth_counter #(.DEPTH(DEPTH)) u_depth (
    .clk(clk), .rst_n(rst_n), .inc(is_call), .dec(is_ret), .ovf(ovf), .unf(unf)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_q | ovf | unf;
  assign bus.err = err_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
  assign bus.err = 1'b0;
`endif
  always_comb begin
    state_d = state;
    pc_d = pc_q;
    addr_d = addr_q;
    push_d = 1'b0;
    pop_d = 1'b0;
    if (state == RET_WAIT) begin
      pc_d = bus.stack_top;
      state_d = RUN;
    end else if (bus.en) begin
      case (bus.op)
        JUMP:    pc_d = bus.target;
        BRANCH:  pc_d = bus.taken ? bus.target : nxt;
        CALL: begin
          pc_d = bus.target;
          addr_d = nxt;
          push_d = !ovf;
        end
        RET: begin
          pop_d = !unf;
          state_d = RET_WAIT;
        end
        default: pc_d = nxt;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      pc_q <= '0;
      addr_q <= '0;
      push_q <= 1'b0;
      pop_q <= 1'b0;
    end else begin
      state <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      push_q <= push_d;
      pop_q <= pop_d;
    end
  assign bus.pc = pc_q;
  assign bus.stack_addr = addr_q;
  assign bus.stack_push = push_q;
  assign bus.stack_pop = pop_q;
  assign bus.busy = state == RET_WAIT;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench with a behavioural negedge return stack.
// Expectations adapt to PC_STACK_GUARD_EN when the bench is built with it.
module tb_pc_sequencer;
  import pc_pkg::*;
`ifdef PC_STACK_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif
  typedef struct {
    string tag;
    logic [27:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [11:0] mem [8];
  logic [2:0] sp;
  logic [11:0] top;
  exp_t sb[$];
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pc_sequencer_if bus ();
  pc_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.stack_top = top;
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      sp <= '0;
      top <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (bus.stack_push) begin
      mem[sp] <= bus.stack_addr;
      sp <= sp + 3'd1;
    end else if (bus.stack_pop) begin
      top <= mem[sp - 3'd1];
      sp <= sp - 3'd1;
    end
  task automatic expect_out(string tag, logic [11:0] p, logic [11:0] a,
                            logic pu, logic po, logic b, logic e);
    exp_t x;
    x.tag = tag;
    x.v = {p, a, pu, po, b, e};
    sb.push_back(x);
  endtask
  task automatic check();
    exp_t x;
    logic [27:0] o;
    x = sb.pop_front();
    o = {bus.pc, bus.stack_addr, bus.stack_push, bus.stack_pop, bus.busy, bus.err};
    n_assert++;
    assert (o === x.v) else begin
      n_fail++;
      $error("FAIL %s: observed pc=%h addr=%h push=%b pop=%b busy=%b err=%b expected pc=%h addr=%h push=%b pop=%b busy=%b err=%b",
             x.tag, o[27:16], o[15:4], o[3], o[2], o[1], o[0],
             x.v[27:16], x.v[15:4], x.v[3], x.v[2], x.v[1], x.v[0]);
    end
  endtask
  task automatic step(logic e, pc_op_t o, logic [11:0] t, logic tk, string tag,
                      logic [11:0] p, logic [11:0] a, logic pu, logic po, logic b, logic er);
    bus.en = e;
    bus.op = o;
    bus.target = t;
    bus.taken = tk;
    expect_out(tag, p, a, pu, po, b, er);
    @(posedge clk);
    #1;
    check();
  endtask
  initial begin
    bus.en = 1'b0;
    bus.op = NEXT;
    bus.target = '0;
    bus.taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 12'h000, 12'h000, 0, 0, 0, 0);
    check();
    rst_n = 1'b1;
    step(1, NEXT, 12'h000, 0, "next1", 12'h001, 12'h000, 0, 0, 0, 0);
    step(1, NEXT, 12'h000, 0, "next2", 12'h002, 12'h000, 0, 0, 0, 0);
    step(1, NEXT, 12'h000, 0, "next3", 12'h003, 12'h000, 0, 0, 0, 0);
    step(1, JUMP, 12'h010, 0, "jump", 12'h010, 12'h000, 0, 0, 0, 0);
    step(1, CALL, 12'h200, 0, "call", 12'h200, 12'h011, 1, 0, 0, 0);
    step(0, CALL, 12'h3ab, 0, "idle", 12'h200, 12'h011, 0, 0, 0, 0);
    step(1, RET, 12'h000, 0, "ret_pop", 12'h200, 12'h011, 0, 1, 1, 0);
    step(1, JUMP, 12'h777, 0, "ret_load", 12'h011, 12'h011, 0, 0, 0, 0);
    step(1, JUMP, 12'h020, 0, "jump20", 12'h020, 12'h011, 0, 0, 0, 0);
    step(1, BRANCH, 12'h080, 0, "br_nt", 12'h021, 12'h011, 0, 0, 0, 0);
    step(1, BRANCH, 12'h080, 1, "br_t", 12'h080, 12'h011, 0, 0, 0, 0);
    step(1, pc_op_t'(3'd5), 12'h555, 1, "op5", 12'h081, 12'h011, 0, 0, 0, 0);
    step(1, pc_op_t'(3'd7), 12'h555, 1, "op7", 12'h082, 12'h011, 0, 0, 0, 0);
    step(1, JUMP, 12'hfff, 0, "jumpfff", 12'hfff, 12'h011, 0, 0, 0, 0);
    step(1, NEXT, 12'h000, 0, "wrap", 12'h000, 12'h011, 0, 0, 0, 0);
    step(1, CALL, 12'h300, 0, "call2", 12'h300, 12'h001, 1, 0, 0, 0);
    step(1, RET, 12'h000, 0, "ret2_pop", 12'h300, 12'h001, 0, 1, 1, 0);
    step(1, NEXT, 12'h000, 0, "ret2_load", 12'h001, 12'h001, 0, 0, 0, 0);
    step(1, JUMP, 12'h055, 0, "jump55", 12'h055, 12'h001, 0, 0, 0, 0);
    step(1, RET, 12'h000, 0, "ret_empty", 12'h055, 12'h001, 0, !G, 1, G);
    #3 rst_n = 1'b0;
    #1;
    expect_out("mid_reset", 12'h000, 12'h000, 0, 0, 0, 0);
    check();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, NEXT, 12'h000, 0, "after_reset", 12'h001, 12'h000, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) begin
      logic [11:0] p;
      p = (i == 0) ? 12'h001 : 12'h100 + 12'(i - 1);
      step(1, CALL, 12'h100 + 12'(i), 0, $sformatf("nest%0d", i), 12'h100 + 12'(i), p + 12'h001,
           (i == 8) ? !G : 1'b1, 0, 0, (i == 8) ? G : 1'b0);
    end
    step(1, RET, 12'h000, 0, "nest_ret", 12'h108, 12'h108, 0, 1, 1, G);
    step(1, NEXT, 12'h000, 0, "nest_load", G ? 12'h107 : 12'h108, 12'h108, 0, 0, 0, G);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the multicycle core: holds the PC and computes the next fetch address for sequential, jump, branch, call and return operations. It drives the push/pop/address side of the 8-entry return-address stack and consumes its top-of-stack output. Calls and returns are sequenced so the stack's negedge update is always complete before the PC consumes it.

## Interface
Parameters:
- ADDR_W, 12, width of PC, targets and stack entries
- DEPTH, 8, return-stack capacity used for depth tracking

Ports:
- clk  in  1  core clock; all state updates on posedge
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  advance: accept op this cycle
- op  in  3  operation code (pc_op_t): NEXT, JUMP, BRANCH, CALL, RET
- target  in  ADDR_W  jump/branch/call destination
- taken  in  1  branch condition, sampled only with BRANCH
- stack_top  in  ADDR_W  current top-of-stack from return stack
- stack_push  out  1  push request to return stack
- stack_pop  out  1  pop request to return stack
- stack_addr  out  ADDR_W  return address to push
- pc  out  ADDR_W  current fetch address
- busy  out  1  sequencer in return wait; en/op ignored
- err  out  1  sticky call-depth overflow/underflow flag

## Operation
- States: RUN, RET_WAIT.
- RUN, en=0: hold pc; push/pop deassert.
- RUN, en=1, by op:
  - NEXT: pc <= pc+1.
  - JUMP: pc <= target.
  - BRANCH: pc <= taken ? target : pc+1.
  - CALL: pc <= target; stack_addr <= pc+1; stack_push <= 1; depth+1.
  - RET: stack_pop <= 1; depth-1; go RET_WAIT; pc held.
- RET_WAIT: pc <= stack_top; return to RUN; en/op ignored.
- Undefined op codes behave as NEXT.
- Arithmetic: pc+1 is modulo 2^ADDR_W; 0xFFF+1 = 0x000 (no carry out, no flag).
- Depth counter 0..DEPTH (width clog2(DEPTH+1)).

## Timing
- Reset values: pc=0, stack_push=0, stack_pop=0, stack_addr=0, busy=0, err=0, depth=0, state RUN.
- stack_push, stack_pop, stack_addr are registered: high for exactly one cycle following the posedge that accepted CALL/RET; stable before the stack's negedge sample.
- CALL: pc updated at accepting edge E0; push occurs during cycle E0..E1; no stall.
- RET: pop during E0..E1; busy=1 in that cycle; pc <= stack_top at E1. Return latency 2 edges, throughput one RET per 2 cycles.
- CALL immediately followed by RET (accepted E1): push occurs cycle 1, pop cycle 2; RET loads the just-pushed address at E2.
- push and pop are never high in the same cycle.
- Reset asserted mid-RET_WAIT: immediate return to RUN with all reset values; pending load discarded.

## Configuration
- PC_STACK_GUARD_EN defined: CALL at depth==DEPTH sets err, suppresses push, still jumps to target; RET at depth==0 sets err, suppresses pop, goes to RET_WAIT and loads stack_top as-is. err clears only on reset.
- Undefined: no depth counter; err tied 0; push/pop always issued (stack pointer wraps silently).

## Structure
- Shared package pc_pkg: pc_op_t enum (NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4), pc_state_t, PC_ADDR_W=12, PC_STACK_DEPTH=8.
- One sub-module: call_depth_counter (up/down saturating counter with overflow/underflow outputs), instantiated only under PC_STACK_GUARD_EN.

## Test plan
- Reset then 3× NEXT with en=1 -> pc 0x001, 0x002, 0x003; push/pop never asserted.
- pc=0x010, CALL target=0x200 -> pc=0x200 next edge, one-cycle stack_push with stack_addr=0x011; RET -> busy 1 cycle, pc=0x011.
- BRANCH target=0x080 with taken=0 then taken=1 from pc=0x020 -> pc 0x021, then 0x080.
- pc=0xFFF, NEXT -> pc=0x000, err=0.
- Guard on: 9 nested CALLs -> 9th sets err, no push on 9th, pc=9th target; RET with depth 0 after reset -> err=1, no stack_pop.
- Assert rst_n low during RET_WAIT -> pc=0, busy=0, stack_pop=0 immediately; first op after release executes normally.
